// File: rtl/aes_arbiter.sv
// Round-robin front end that shares one aes_core between two requesters.
// Define AES_ARB_TIMEOUT_EN to abort BUSY after TIMEOUT_CYCLES cycles without core_done.
module aes_arbiter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   req,
  input  logic [127:0] key0,
  input  logic [127:0] plaintext0,
  input  logic [127:0] key1,
  input  logic [127:0] plaintext1,
  output logic [1:0]   ack,
  output logic         rsp_valid,
  output logic         rsp_id,
  output logic [127:0] rsp_data,
  output logic         rsp_timeout,
  output logic         core_load,
  output logic [127:0] core_key,
  output logic [127:0] core_plaintext,
  input  logic         core_done,
  input  logic [127:0] core_cyphertext
);

  typedef enum logic [1:0] {IDLE, LOAD, BUSY, RESP} state_t;

  state_t state, state_next;
  logic   load_second;
  logic   owner;
  logic   last_grant;
  logic   winner;
  logic   capture;
  logic   finish;
  logic   abort;
  logic   expire;

  // On a tie the requester that was not served last wins.
  always_comb begin
    winner = req[1];
    if (req == 2'b11) winner = ~last_grant;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    finish     = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: if (req != 2'b00) begin
        capture    = 1'b1;
        state_next = LOAD;
      end
      LOAD: if (load_second) state_next = BUSY;
      BUSY: if (core_done) begin
        finish     = 1'b1;
        state_next = RESP;
      end else if (expire) begin
        abort      = 1'b1;
        state_next = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // core_done is not looked at during LOAD, so a done level left over from the
  // previous operation cannot be mistaken for this one's result.
  always_ff @(posedge clk) begin
    if (reset) begin
      ack            <= 2'b00;
      rsp_valid      <= 1'b0;
      rsp_id         <= 1'b0;
      rsp_data       <= '0;
      core_load      <= 1'b0;
      core_key       <= '0;
      core_plaintext <= '0;
      owner          <= 1'b0;
      last_grant     <= 1'b1;
      load_second    <= 1'b0;
    end else begin
      ack         <= 2'b00;
      rsp_valid   <= finish | abort;
      core_load   <= (state_next == LOAD);
      load_second <= (state == LOAD) && !load_second;
      if (capture) begin
        owner          <= winner;
        ack            <= winner ? 2'b10 : 2'b01;
        core_key       <= winner ? key1 : key0;
        core_plaintext <= winner ? plaintext1 : plaintext0;
      end
      if (finish | abort) begin
        rsp_id   <= owner;
        rsp_data <= finish ? core_cyphertext : '0;
      end
      if (state == RESP) last_grant <= owner;
    end
  end

`ifdef AES_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] busy_cnt;

  assign expire = (busy_cnt == CW'(TIMEOUT_CYCLES - 1));

  // Counts BUSY cycles without done; a done arriving on the expiry cycle still wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_cnt    <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      if (state != BUSY)               busy_cnt <= '0;
      else if (!core_done && !expire)  busy_cnt <= busy_cnt + CW'(1);
      if (finish)     rsp_timeout <= 1'b0;
      else if (abort) rsp_timeout <= 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;

  assign expire             = 1'b0;
  assign rsp_timeout        = 1'b0;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  ack_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(ack));
  ack_in_load: assert property (@(posedge clk) disable iff (reset) (ack != 2'b00) |-> (state == LOAD));
  rsp_in_resp: assert property (@(posedge clk) disable iff (reset) rsp_valid |-> (state == RESP));

endmodule

// File: tb/tb_aes_arbiter.sv
// Self-checking bench for aes_arbiter: directed vector table, corner sequences and
// randomized traffic, all checked against a transaction-level reference model.
module tb_aes_arbiter;

  localparam int TIMEOUT = 64;
`ifdef AES_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam logic [127:0] KEY_A = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
  localparam logic [127:0] PT_A  = 128'h3243F6A8885A308D313198A2E0370734;
  localparam logic [127:0] CT_A  = 128'h3925841D02DC09FBDC118597196A0B32;
  localparam logic [127:0] KEY_B = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] PT_B  = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] CT_B  = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;

  typedef struct {
    logic [1:0]   req;
    logic [127:0] k0;
    logic [127:0] p0;
    logic [127:0] k1;
    logic [127:0] p1;
    int           lat;
    int           n;
    logic         id0;
    logic [127:0] d0;
    logic         id1;
    logic [127:0] d1;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [1:0]   req = 2'b00;
  logic [127:0] kq [2];
  logic [127:0] pq [2];
  logic [1:0]   ack;
  logic         rsp_valid;
  logic         rsp_id;
  logic [127:0] rsp_data;
  logic         rsp_timeout;
  logic         core_load;
  logic [127:0] core_key;
  logic [127:0] core_plaintext;
  logic         core_done = 1'b0;
  logic [127:0] core_cyphertext = '0;

  int n_compared = 0;
  int n_mismatch = 0;
  bit auto_drop = 1'b1;
  int core_lat = 3;
  bit core_hang = 1'b0;

  aes_arbiter #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req(req),
    .key0(kq[0]), .plaintext0(pq[0]), .key1(kq[1]), .plaintext1(pq[1]),
    .ack(ack), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_timeout(rsp_timeout), .core_load(core_load), .core_key(core_key),
    .core_plaintext(core_plaintext), .core_done(core_done),
    .core_cyphertext(core_cyphertext)
  );

  always #5 clk = ~clk;

  // Stand-in for the AES core: known vectors give real cyphertext, anything else a keyed scramble.
  function automatic logic [127:0] cipher(input logic [127:0] k, input logic [127:0] p);
    if (k == KEY_A && p == PT_A) return CT_A;
    if (k == KEY_B && p == PT_B) return CT_B;
    return k ^ {p[63:0], p[127:64]} ^ 128'hA5A5_5A5A_0F0F_F0F0_1234_5678_9ABC_DEF0;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  int           core_remaining = 0;
  logic [127:0] core_lk = '0;
  logic [127:0] core_lp = '0;

  // done stays high until the next load, so the arbiter sees a stale done during LOAD.
  always @(posedge clk) begin
    if (core_load) begin
      core_done       <= 1'b0;
      core_cyphertext <= 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
      core_remaining  <= core_lat;
      core_lk         <= core_key;
      core_lp         <= core_plaintext;
    end else if (core_remaining > 0) begin
      core_remaining <= core_remaining - 1;
      if (core_remaining == 1 && !core_hang) begin
        core_done       <= 1'b1;
        core_cyphertext <= cipher(core_lk, core_lp);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatch++;
      $display("[TB] FAIL %s: got %h, want %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference model: tracks whether the arbiter is free, which request it owes, and when
  // the response is due (first cycle after done is seen in BUSY, or on timeout).
  bit           m_idle = 1'b1;
  bit           m_busy = 1'b0;
  bit           m_rsp_last = 1'b0;
  bit           m_owner = 1'b0;
  bit           m_last = 1'b1;
  bit           m_done_prev = 1'b0;
  int           m_age = 0;
  logic [127:0] m_data = '0;
  logic [127:0] m_key = '0;
  logic [127:0] m_pt = '0;
  logic [127:0] h_data = '0;
  logic         h_id = 1'b0;
  logic         h_to = 1'b0;

  task automatic modelCycle();
    logic [1:0] e_ack;
    logic       e_rsp;
    logic       e_load;
    logic       w;
    e_ack  = 2'b00;
    e_rsp  = 1'b0;
    e_load = 1'b0;
    if (reset) begin
      m_busy = 1'b0; m_last = 1'b1; m_key = '0; m_pt = '0;
      h_id = 1'b0; h_data = '0; h_to = 1'b0;
      m_idle = 1'b1; m_rsp_last = 1'b0;
    end else begin
      if (m_idle && req != 2'b00) begin
        w       = (req == 2'b11) ? !m_last : req[1];
        e_ack   = w ? 2'b10 : 2'b01;
        m_busy  = 1'b1;
        m_owner = w;
        m_age   = 0;
        m_key   = kq[w];
        m_pt    = pq[w];
        m_data  = cipher(m_key, m_pt);
      end else if (m_busy) begin
        m_age++;
        if (m_age >= 3 && m_done_prev) begin
          e_rsp = 1'b1; h_data = m_data; h_to = 1'b0;
        end else if (TO_EN && m_age == 2 + TIMEOUT) begin
          e_rsp = 1'b1; h_data = '0; h_to = 1'b1;
        end
        if (e_rsp) begin
          m_busy = 1'b0; m_last = m_owner; h_id = m_owner;
        end
      end
      e_load     = m_busy && m_age <= 1;
      m_idle     = (m_idle && e_ack == 2'b00) || m_rsp_last;
      m_rsp_last = e_rsp;
    end
    m_done_prev = core_done;
    checkOutput("ack", 128'(ack), 128'(e_ack));
    checkOutput("rsp_valid", 128'(rsp_valid), 128'(e_rsp));
    checkOutput("core_load", 128'(core_load), 128'(e_load));
    checkOutput("rsp_id", 128'(rsp_id), 128'(h_id));
    checkOutput("rsp_data", rsp_data, h_data);
    checkOutput("rsp_timeout", 128'(rsp_timeout), 128'(h_to));
    checkOutput("core_key", core_key, m_key);
    checkOutput("core_plaintext", core_plaintext, m_pt);
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    modelCycle();
  end

  task automatic stepCycle();
    @(posedge clk);
    #2;
    if (auto_drop)
      for (int i = 0; i < 2; i++)
        if (ack[i]) req[i] = 1'b0;
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    stepCycle();
    reset = 1'b0;
  endtask

  task automatic waitAck(input string name);
    int n;
    n = 0;
    while (ack == 2'b00 && n < 20) begin
      stepCycle();
      n++;
    end
    checkOutput({name, " ack seen"}, 128'(ack != 2'b00), 128'(1));
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    int got;
    int budget;
    pulseReset();
    kq[0] = v.k0; pq[0] = v.p0; kq[1] = v.k1; pq[1] = v.p1;
    core_lat = v.lat;
    req = v.req;
    got = 0;
    budget = 0;
    while (got < v.n && budget < 200) begin
      stepCycle();
      budget++;
      if (rsp_valid) begin
        checkOutput($sformatf("vec%0d rsp%0d id", idx, got), 128'(rsp_id), 128'(got == 0 ? v.id0 : v.id1));
        checkOutput($sformatf("vec%0d rsp%0d data", idx, got), rsp_data, got == 0 ? v.d0 : v.d1);
        checkOutput($sformatf("vec%0d rsp%0d timeout", idx, got), 128'(rsp_timeout), 128'(0));
        got++;
      end
    end
    checkOutput($sformatf("vec%0d response count", idx), 128'(got), 128'(v.n));
    req = 2'b00;
    repeat (3) stepCycle();
  endtask

  vec_t vecs [5];

  initial begin
    int got;
    int n;
    int age;
    logic exp_rr [4];
    kq[0] = '0; kq[1] = '0; pq[0] = '0; pq[1] = '0;
    repeat (3) stepCycle();
    reset = 1'b0;

    vecs[0] = '{2'b01, KEY_A, PT_A, '0, '0, 3, 1, 1'b0, CT_A, 1'b0, '0};
    vecs[1] = '{2'b11, KEY_A, PT_A, KEY_B, PT_B, 3, 2, 1'b0, CT_A, 1'b1, CT_B};
    vecs[2] = '{2'b10, '0, '0, KEY_B, PT_B, 2, 1, 1'b1, CT_B, 1'b0, '0};
    vecs[3] = '{2'b11, KEY_B, PT_B, KEY_A, PT_A, 7, 2, 1'b0, CT_B, 1'b1, CT_A};
    vecs[4] = '{2'b01, KEY_A, PT_A, '0, '0, 1, 1, 1'b0, CT_A, 1'b0, '0};
    for (int i = 0; i < 5; i++) applyStimulus(vecs[i], i);

    // Both requesters held high: grants must alternate starting with requester 0.
    pulseReset();
    auto_drop = 1'b0;
    kq[0] = KEY_A; pq[0] = PT_A; kq[1] = KEY_B; pq[1] = PT_B;
    core_lat = 2;
    exp_rr = '{1'b0, 1'b1, 1'b0, 1'b1};
    req = 2'b11;
    got = 0;
    n = 0;
    while (got < 4 && n < 200) begin
      stepCycle();
      n++;
      if (rsp_valid) begin
        checkOutput($sformatf("rr id %0d", got), 128'(rsp_id), 128'(exp_rr[got]));
        got++;
      end
    end
    req = 2'b00;
    auto_drop = 1'b1;
    checkOutput("rr response count", 128'(got), 128'(4));
    repeat (3) stepCycle();

    // Reset in the middle of BUSY: the aborted operation must never respond.
    core_lat = 20;
    kq[0] = KEY_A; pq[0] = PT_A;
    req = 2'b01;
    waitAck("busy-reset");
    repeat (4) stepCycle();
    pulseReset();
    checkOutput("busy-reset core_load", 128'(core_load), 128'(0));
    checkOutput("busy-reset ack", 128'(ack), 128'(0));
    got = 0;
    for (int c = 0; c < 30; c++) begin
      stepCycle();
      if (rsp_valid) got++;
    end
    checkOutput("busy-reset stray responses", 128'(got), 128'(0));
    core_lat = 4;
    req = 2'b01;
    got = 0;
    n = 0;
    while (!rsp_valid && n < 50) begin
      stepCycle();
      n++;
    end
    checkOutput("after-reset rsp_valid", 128'(rsp_valid), 128'(1));
    checkOutput("after-reset rsp_data", rsp_data, CT_A);
    checkOutput("after-reset rsp_id", 128'(rsp_id), 128'(0));
    repeat (3) stepCycle();

    // Core that never finishes.
    pulseReset();
    core_hang = 1'b1;
    req = 2'b01;
    waitAck("hang");
    age = 0;
    while (!rsp_valid && age < 200) begin
      stepCycle();
      age++;
    end
`ifdef AES_ARB_TIMEOUT_EN
    checkOutput("timeout latency", 128'(age), 128'(2 + TIMEOUT));
    checkOutput("timeout flag", 128'(rsp_timeout), 128'(1));
    checkOutput("timeout data", rsp_data, 128'(0));
`else
    checkOutput("hang rsp_valid", 128'(rsp_valid), 128'(0));
    checkOutput("hang cycles", 128'(age), 128'(200));
`endif
    core_hang = 1'b0;
    pulseReset();
    repeat (40) stepCycle();

`ifdef AES_ARB_TIMEOUT_EN
    // done lands on the same cycle the timeout expires: the result must win.
    pulseReset();
    core_lat = TIMEOUT - 1;
    kq[0] = KEY_A; pq[0] = PT_A;
    req = 2'b01;
    waitAck("tie");
    age = 0;
    while (!rsp_valid && age < 200) begin
      stepCycle();
      age++;
    end
    checkOutput("tie latency", 128'(age), 128'(2 + TIMEOUT));
    checkOutput("tie timeout flag", 128'(rsp_timeout), 128'(0));
    checkOutput("tie data", rsp_data, CT_A);
    repeat (3) stepCycle();
`endif

    // Randomized traffic: raises, withdrawals, varying core latency, rare resets.
    pulseReset();
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!req[i] && $urandom_range(3) == 0) begin
          kq[i] = ($urandom_range(3) == 0) ? KEY_A : rand128();
          pq[i] = (kq[i] == KEY_A) ? PT_A : rand128();
          req[i] = 1'b1;
        end else if (req[i] && $urandom_range(15) == 0) begin
          req[i] = 1'b0;
        end
      end
      core_lat = $urandom_range(8, 1);
      reset = ($urandom_range(199) == 0);
      stepCycle();
    end
    reset = 1'b0;
    req = 2'b00;
    repeat (20) stepCycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, compared %0d", n_compared);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
